// File: rtl/memory_access.sv
// Memory stage of the five-stage MIPS pipeline: word-addressed data memory with
// a configurable access latency, pipeline stall and registered MEM/WB bundle.
module memory_access #(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_MemtoReg,
  input  logic        XM_RegWrite,
  input  logic        XM_MemRead,
  input  logic        XM_MemWrite,
  input  logic        XM_branch,
  input  logic [31:0] ALUout,
  input  logic [31:0] XM_BT,
  input  logic [4:0]  XM_RD,
  input  logic [4:0]  XM_MD,
  input  logic [31:0] XM_SD,
  output logic        MW_MemtoReg,
  output logic        MW_RegWrite,
  output logic [31:0] MW_ALUout,
  output logic [31:0] MW_LMD,
  output logic [4:0]  MW_RD,
  output logic [4:0]  MW_MD,
  output logic        PC_src,
  output logic [31:0] PC_target,
  output logic        mem_stall,
  output logic        misalign
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  logic [0:0]        state;
  logic [3:0]        cnt;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              is_mem;
  logic              access;
  logic              bad_access;
  logic              retire;
  logic              unused_addr;

  assign idx         = ALUout[ADDR_W+1:2];
  assign unused_addr = ^ALUout[31:ADDR_W+2];
  assign is_mem      = XM_MemRead | XM_MemWrite;
  assign access      = is_mem & (ALUout[1:0] == 2'b00);
  assign bad_access  = is_mem & (ALUout[1:0] != 2'b00);

  // An instruction leaves the stage on this edge unless a multi-cycle access is
  // still counting down; a single wait cycle completes straight from IDLE.
  assign retire = (state == IDLE) ? !(access && (WAIT_CYC > 1))
                                  : (cnt == 4'd2);

  assign mem_stall = ((state == IDLE) && access && (WAIT_CYC > 0)) ||
                     ((state == BUSY) && (cnt > 4'd1));

  assign PC_src    = XM_branch;
  assign PC_target = XM_BT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      MW_MemtoReg <= 1'b0;
      MW_RegWrite <= 1'b0;
      MW_ALUout   <= '0;
      MW_LMD      <= '0;
      MW_RD       <= '0;
      MW_MD       <= '0;
      misalign    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (access && (WAIT_CYC > 1)) begin
          state <= BUSY;
          cnt   <= WAIT_LD;
        end
      end else if (cnt == 4'd2) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt - 4'd1;
      end

      if (retire) begin
        MW_MemtoReg <= XM_MemtoReg;
        MW_RegWrite <= XM_RegWrite;
        MW_ALUout   <= ALUout;
        MW_RD       <= XM_RD;
        MW_MD       <= XM_MD;
        // Read-before-write: a combined read/write returns the old word.
        if (access)          MW_LMD <= mem[idx];
        else if (bad_access) MW_LMD <= '0;
        if (bad_access)      misalign <= 1'b1;
      end else begin
        MW_MemtoReg <= 1'b0;
        MW_RegWrite <= 1'b0;
      end
    end
  end

  // NOTE: the data array has no reset branch; contents survive rst, and only
  // the commit is blocked while rst is high so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!rst && retire && access && XM_MemWrite) mem[idx] <= XM_SD;
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: one zero-latency and one two-wait-cycle
// instance, each checked against a transaction-level model of the stage.
module tb_memory_access;

  typedef struct packed {
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic [31:0] alu;
    logic [31:0] bt;
    logic [4:0]  rd;
    logic [4:0]  md;
    logic [31:0] sd;
  } xm_t;

  typedef struct packed {
    logic        memtoreg;
    logic        regwrite;
    logic [31:0] alu;
    logic [31:0] lmd;
    logic [4:0]  rd;
    logic [4:0]  md;
    logic        mis;
  } mw_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: WAIT_CYC=0 instance, index 1: WAIT_CYC=2 instance
  logic        rst [2];
  xm_t         x   [2];
  logic        mtr [2], rw [2], pcs [2], stl [2], mis [2];
  logic [31:0] alu [2], lmd [2], pct [2];
  logic [4:0]  rd  [2], md [2];
  mw_t         got [2];

  memory_access #(.DEPTH(256), .ADDR_W(8), .WAIT_CYC(0)) u0 (
    .clk(clk), .rst(rst[0]),
    .XM_MemtoReg(x[0].memtoreg), .XM_RegWrite(x[0].regwrite),
    .XM_MemRead(x[0].memread), .XM_MemWrite(x[0].memwrite),
    .XM_branch(x[0].branch), .ALUout(x[0].alu), .XM_BT(x[0].bt),
    .XM_RD(x[0].rd), .XM_MD(x[0].md), .XM_SD(x[0].sd),
    .MW_MemtoReg(mtr[0]), .MW_RegWrite(rw[0]), .MW_ALUout(alu[0]),
    .MW_LMD(lmd[0]), .MW_RD(rd[0]), .MW_MD(md[0]),
    .PC_src(pcs[0]), .PC_target(pct[0]), .mem_stall(stl[0]), .misalign(mis[0])
  );

  memory_access #(.DEPTH(256), .ADDR_W(8), .WAIT_CYC(2)) u2 (
    .clk(clk), .rst(rst[1]),
    .XM_MemtoReg(x[1].memtoreg), .XM_RegWrite(x[1].regwrite),
    .XM_MemRead(x[1].memread), .XM_MemWrite(x[1].memwrite),
    .XM_branch(x[1].branch), .ALUout(x[1].alu), .XM_BT(x[1].bt),
    .XM_RD(x[1].rd), .XM_MD(x[1].md), .XM_SD(x[1].sd),
    .MW_MemtoReg(mtr[1]), .MW_RegWrite(rw[1]), .MW_ALUout(alu[1]),
    .MW_LMD(lmd[1]), .MW_RD(rd[1]), .MW_MD(md[1]),
    .PC_src(pcs[1]), .PC_target(pct[1]), .mem_stall(stl[1]), .misalign(mis[1])
  );

  assign got[0] = {mtr[0], rw[0], alu[0], lmd[0], rd[0], md[0], mis[0]};
  assign got[1] = {mtr[1], rw[1], alu[1], lmd[1], rd[1], md[1], mis[1]};

  int errors = 0;
  int checks = 0;

  // Reference model: architectural memory plus the expected MEM/WB bundle.
  logic [31:0] mdl  [2][256];
  mw_t         expv [2];

  function automatic logic is_acc(xm_t v);
    return (v.memread || v.memwrite) && (v.alu[1:0] == 2'b00);
  endfunction

  function automatic void model_commit(int k, xm_t v);
    int w;
    w = int'(v.alu[9:2]);
    expv[k].memtoreg = v.memtoreg;
    expv[k].regwrite = v.regwrite;
    expv[k].alu      = v.alu;
    expv[k].rd       = v.rd;
    expv[k].md       = v.md;
    if (v.memread || v.memwrite) begin
      if (v.alu[1:0] != 2'b00) begin
        expv[k].lmd = 32'h0;
        expv[k].mis = 1'b1;
      end else begin
        expv[k].lmd = mdl[k][w];
        if (v.memwrite) mdl[k][w] = v.sd;
      end
    end
  endfunction

  function automatic void model_bubble(int k);
    expv[k].memtoreg = 1'b0;
    expv[k].regwrite = 1'b0;
  endfunction

  function automatic xm_t mk(logic r_en, logic w_en, logic [31:0] a, logic [31:0] d,
                             logic [4:0] r, logic wr_reg, logic m2r);
    xm_t v;
    v          = '0;
    v.memread  = r_en;
    v.memwrite = w_en;
    v.alu      = a;
    v.sd       = d;
    v.rd       = r;
    v.md       = r ^ 5'h1f;
    v.regwrite = wr_reg;
    v.memtoreg = m2r;
    return v;
  endfunction

  function automatic xm_t rand_xm();
    xm_t         v;
    logic [31:0] hi;
    int          sel;
    v.memread  = 1'($urandom_range(0, 1));
    v.memwrite = 1'($urandom_range(0, 1));
    v.branch   = !(v.memread || v.memwrite) && ($urandom_range(0, 1) == 1);
    v.memtoreg = 1'($urandom_range(0, 1));
    v.regwrite = 1'($urandom_range(0, 1));
    hi         = $urandom();
    sel        = $urandom_range(0, 15);
    v.alu      = (hi & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) |
                 ((sel == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
    v.bt       = $urandom();
    v.rd       = 5'($urandom_range(0, 31));
    v.md       = 5'($urandom_range(0, 31));
    v.sd       = $urandom();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction to completion and advances the model; no checking.
  task automatic run(int k, xm_t v);
    x[k] = v;
    if (k == 1 && is_acc(v)) begin
      tick();
      model_bubble(1);
    end
    tick();
    model_commit(k, v);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      x[k]   = '0;
      expv[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      #1;
      checks++;
      if (got[k] !== mw_t'('0)) begin
        errors++;
        $display("FAIL reset_bundle[%0d] got=%h exp=0", k, got[k]);
      end
      checks++;
      if (stl[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall[%0d] got=%b exp=0", k, stl[k]);
      end
    end
  endtask

  task automatic test_store_load();
    x[0] = mk(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stl[0] !== 1'b0) begin
      errors++;
      $display("FAIL w0_store_stall got=%b exp=0", stl[0]);
    end
    tick();
    model_commit(0, x[0]);
    x[0] = mk(1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b1);
    #1;
    checks++;
    if (stl[0] !== 1'b0) begin
      errors++;
      $display("FAIL w0_load_stall got=%b exp=0", stl[0]);
    end
    tick();
    model_commit(0, x[0]);
    checks++;
    if ({lmd[0], rd[0], rw[0]} !== {32'hDEAD_BEEF, 5'd5, 1'b1}) begin
      errors++;
      $display("FAIL w0_load_data got lmd=%h rd=%0d rw=%b exp lmd=deadbeef rd=5 rw=1",
               lmd[0], rd[0], rw[0]);
    end
    checks++;
    if (got[0] !== expv[0]) begin
      errors++;
      $display("FAIL w0_load_bundle got=%h exp=%h", got[0], expv[0]);
    end
  endtask

  task automatic test_wrap();
    run(0, mk(1'b0, 1'b1, 32'h400, 32'd7, 5'd0, 1'b0, 1'b0));
    run(0, mk(1'b1, 1'b0, 32'h000, 32'h0, 5'd3, 1'b1, 1'b1));
    checks++;
    if (lmd[0] !== 32'd7) begin
      errors++;
      $display("FAIL wrap_load got=%h exp=00000007", lmd[0]);
    end
  endtask

  task automatic test_misalign();
    run(0, mk(1'b0, 1'b1, 32'h13, 32'h1234_5678, 5'd2, 1'b1, 1'b0));
    checks++;
    if ({mis[0], lmd[0], rw[0]} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL misalign_store got mis=%b lmd=%h rw=%b exp mis=1 lmd=0 rw=1",
               mis[0], lmd[0], rw[0]);
    end
    run(0, mk(1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 1'b1, 1'b1));
    checks++;
    if (lmd[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL misalign_mem_unchanged got=%h exp=deadbeef", lmd[0]);
    end
    for (int i = 0; i < 3; i++) begin
      run(0, mk(1'b0, 1'b0, 32'($urandom()), 32'h0, 5'd1, 1'b1, 1'b0));
      checks++;
      if (mis[0] !== 1'b1) begin
        errors++;
        $display("FAIL misalign_sticky[%0d] got=%b exp=1", i, mis[0]);
      end
    end
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    expv[0] = '0;
    checks++;
    if (mis[0] !== 1'b0) begin
      errors++;
      $display("FAIL misalign_cleared got=%b exp=0", mis[0]);
    end
  endtask

  task automatic test_branch();
    for (int r = 0; r < 2; r++) begin
      x[0]          = mk(1'b0, 1'b0, 32'h44, 32'h0, 5'd9, 1'(r), 1'b0);
      x[0].branch   = 1'b1;
      x[0].bt       = 32'h40;
      #1;
      checks++;
      if ({pcs[0], pct[0]} !== {1'b1, 32'h40}) begin
        errors++;
        $display("FAIL branch_redirect got src=%b tgt=%h exp src=1 tgt=40", pcs[0], pct[0]);
      end
      tick();
      model_commit(0, x[0]);
      checks++;
      if (rw[0] !== 1'(r)) begin
        errors++;
        $display("FAIL branch_regwrite got=%b exp=%0d", rw[0], r);
      end
    end
  endtask

  task automatic test_wait_load();
    run(1, mk(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0));
    run(1, mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0));
    x[1] = mk(1'b1, 1'b0, 32'h20, 32'h0, 5'd9, 1'b1, 1'b1);
    #1;
    checks++;
    if (stl[1] !== 1'b1) begin
      errors++;
      $display("FAIL w2_stall_cycle0 got=%b exp=1", stl[1]);
    end
    tick();
    model_bubble(1);
    checks++;
    if ({rw[1], stl[1]} !== 2'b01) begin
      errors++;
      $display("FAIL w2_bubble got rw=%b stall=%b exp rw=0 stall=1", rw[1], stl[1]);
    end
    checks++;
    if (got[1] !== expv[1]) begin
      errors++;
      $display("FAIL w2_bubble_bundle got=%h exp=%h", got[1], expv[1]);
    end
    tick();
    model_commit(1, x[1]);
    checks++;
    if ({lmd[1], rw[1]} !== {32'hCAFE_F00D, 1'b1}) begin
      errors++;
      $display("FAIL w2_load_done got lmd=%h rw=%b exp lmd=cafef00d rw=1", lmd[1], rw[1]);
    end
    x[1] = mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stl[1] !== 1'b0) begin
      errors++;
      $display("FAIL w2_stall_released got=%b exp=0", stl[1]);
    end
    tick();
    model_commit(1, x[1]);
  endtask

  task automatic test_reset_busy();
    run(1, mk(1'b0, 1'b1, 32'h8, 32'h0, 5'd0, 1'b0, 1'b0));
    x[1] = mk(1'b0, 1'b1, 32'h8, 32'h55, 5'd6, 1'b1, 1'b0);
    tick();
    checks++;
    if (stl[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstbusy_in_busy got stall=%b exp=1", stl[1]);
    end
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    expv[1] = '0;
    checks++;
    if (got[1] !== mw_t'('0)) begin
      errors++;
      $display("FAIL rstbusy_outputs got=%h exp=0", got[1]);
    end
    x[1] = mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stl[1] !== 1'b0) begin
      errors++;
      $display("FAIL rstbusy_stall got=%b exp=0", stl[1]);
    end
    run(1, mk(1'b1, 1'b0, 32'h8, 32'h0, 5'd7, 1'b1, 1'b1));
    checks++;
    if (lmd[1] !== 32'h0) begin
      errors++;
      $display("FAIL rstbusy_store_dropped got=%h exp=0", lmd[1]);
    end
  endtask

  // The first 16 instructions are aligned stores sweeping the address window
  // so every later load hits a word the model already knows.
  task automatic test_random(int k, int n);
    xm_t v;
    logic exp_stall;
    for (int i = 0; i < n + 16; i++) begin
      if (i < 16) v = mk(1'b0, 1'b1, 32'(i) << 2, $urandom(), 5'd0, 1'b0, 1'b0);
      else        v = rand_xm();
      exp_stall = (k == 1) && is_acc(v);
      x[k] = v;
      #1;
      checks++;
      if ({stl[k], pcs[k], pct[k]} !== {exp_stall, v.branch, v.bt}) begin
        errors++;
        $display("FAIL rand%0d_comb[%0d] got stall=%b src=%b tgt=%h exp stall=%b src=%b tgt=%h",
                 k, i, stl[k], pcs[k], pct[k], exp_stall, v.branch, v.bt);
      end
      if (exp_stall) begin
        tick();
        model_bubble(k);
        checks++;
        if (got[k] !== expv[k]) begin
          errors++;
          $display("FAIL rand%0d_bubble[%0d] got=%h exp=%h", k, i, got[k], expv[k]);
        end
      end
      tick();
      model_commit(k, v);
      checks++;
      if (got[k] !== expv[k]) begin
        errors++;
        $display("FAIL rand%0d_bundle[%0d] got=%h exp=%h", k, i, got[k], expv[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 256; w++) mdl[k][w] = 32'h0;
    test_reset();
    test_store_load();
    test_wrap();
    test_misalign();
    test_branch();
    test_wait_load();
    test_reset_busy();
    test_random(0, 150);
    test_random(1, 150);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
